// File: rtl/host_instr_sender.sv
// Host-side instruction sender: encodes commands into 64-bit accelerator words,
// expands LOAD bursts, honours buffer_full and returns READ_OUT results.
module host_instr_sender #(
  parameter int unsigned RD_LATENCY = 6,
  parameter int unsigned LEN_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [13:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic [63:0]      accelerator_input,
  output logic             instr_strobe,
  input  logic             buffer_full,
  input  logic [31:0]      accelerator_output,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT_RD, RESP} state_t;

  localparam logic [3:0] OP_LOAD_INP = 4'd1;
  localparam logic [3:0] OP_LOAD_WT  = 4'd2;
  localparam logic [3:0] OP_READ_OUT = 4'd5;
  localparam logic [3:0] OP_MAX      = 4'd6;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [13:0]      addr_q;
  logic [LEN_W-1:0] beat_q;
  logic [3:0]       lat_q;
  logic [63:0]      word_q;
  logic [31:0]      rsp_q;

  logic        is_load, is_read, issue, cmd_live, more_beats, lat_hit;
  logic [63:0] word_now;

  assign is_load    = (op_q == OP_LOAD_INP) || (op_q == OP_LOAD_WT);
  assign is_read    = (op_q == OP_READ_OUT);
  assign cmd_live   = (cmd_op != 4'd0) && (cmd_op <= OP_MAX);
  assign more_beats = is_load && (beat_q > LEN_W'(1));
  assign lat_hit    = (lat_q == 4'(RD_LATENCY));
  assign issue      = (state == ISSUE) && !buffer_full && (!is_load || wdata_valid);
  assign word_now   = {op_q, addr_q, 14'd0, (is_load ? wdata : 32'd0)};

  // The word is presented combinationally in the strobe cycle so wdata is
  // consumed in that same cycle; afterwards the registered copy holds it.
  assign accelerator_input = issue ? word_now : word_q;
  assign instr_strobe      = issue;
  assign wdata_ready       = issue && is_load;
  assign cmd_ready         = (state == IDLE) && rst;
  assign busy              = (state != IDLE);
  assign rsp_valid         = (state == RESP);
  assign rsp_data          = rsp_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_live) state_nx = ISSUE;
      ISSUE:   if (issue) state_nx = GAP;
      GAP: begin
        if (more_beats)   state_nx = ISSUE;
        else if (is_read) state_nx = lat_hit ? RESP : WAIT_RD;
        else              state_nx = IDLE;
      end
      WAIT_RD: if (lat_hit) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= '0;
      addr_q <= '0;
      beat_q <= '0;
      lat_q  <= '0;
      word_q <= '0;
      rsp_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        beat_q <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
      end
      if (issue) begin
        word_q <= word_now;
        lat_q  <= 4'd1;
      end
      // lat_q equals the number of cycles elapsed since the strobe cycle
      if (state == GAP || state == WAIT_RD) begin
        lat_q <= lat_q + 4'd1;
        if (is_read && lat_hit) rsp_q <= accelerator_output;
      end
      if (state == GAP && more_beats) begin
        addr_q <= addr_q + 14'd1;
        beat_q <= beat_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_host_instr_sender.sv
// Directed + randomized bench for host_instr_sender with a word-list reference model.
`timescale 1ns/1ps
module tb_host_instr_sender;
  localparam int unsigned RD_LAT = 6;
  localparam int unsigned LW     = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [13:0]   cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdata_valid = 1'b0, wdata_ready;
  logic [31:0]   wdata = '0;
  logic [63:0]   accelerator_input;
  logic          instr_strobe;
  logic          buffer_full, bf_dir = 1'b0, bf_noise = 1'b0;
  logic [31:0]   accelerator_output = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic          busy;

  assign buffer_full = bf_dir | bf_noise;

  host_instr_sender #(.RD_LATENCY(RD_LAT), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .accelerator_input(accelerator_input), .instr_strobe(instr_strobe),
    .buffer_full(buffer_full), .accelerator_output(accelerator_output),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  logic [63:0] stb_w[$];
  int          stb_c[$];
  logic [63:0] exp_w[$];
  logic [31:0] wq[$];
  int          rd_cyc = -100;
  logic [31:0] rd_val = '0;
  bit          take = 0, rnd_stall = 0, rv_seen = 0;
  int          wdr_n = 0, wdr_bad = 0, hold_bad = 0;
  logic [63:0] last_w = '0;

  int          n0, rel, rv_c, a, len, opi;
  logic [31:0] d0, d1, d2;
  logic [3:0]  op;

  function automatic logic [63:0] mkw(logic [3:0] o, logic [13:0] ad, logic [31:0] d);
    return {o, ad, 14'h0, d};
  endfunction

  // Observer: strobed words, wdata consumption, hold-stability of the instruction bus
  always @(negedge clk) begin
    if (!rst) last_w = '0;
    else if (instr_strobe) begin
      stb_w.push_back(accelerator_input);
      stb_c.push_back(cyc);
      last_w = accelerator_input;
      if (accelerator_input[63:60] == 4'd5) rd_cyc = cyc + int'(RD_LAT);
    end else if (accelerator_input !== last_w) hold_bad++;
    if (wdata_ready) begin
      wdr_n++;
      if (!instr_strobe || !(accelerator_input[63:60] inside {4'd1, 4'd2})) wdr_bad++;
    end
    if (wdata_valid && wdata_ready) take = 1;
    if (rsp_valid) rv_seen = 1;
  end

  // Data source and accelerator result model (valid only in the exact latency cycle)
  always @(posedge clk) begin
    #1;
    if (take && wq.size() > 0) void'(wq.pop_front());
    take = 0;
    wdata_valid = (wq.size() > 0) && (!rnd_stall || $urandom_range(0, 1) == 1);
    wdata = (wq.size() > 0) ? wq[0] : '0;
    bf_noise = rnd_stall && ($urandom_range(0, 3) == 0);
    accelerator_output = (cyc == rd_cyc) ? rd_val : $urandom;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic send(logic [3:0] o, logic [13:0] ad, logic [LW-1:0] l);
    bit ok = 0;
    cmd_op = o; cmd_addr = ad; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      tick;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 400 && busy; i++) tick;
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_stb(int n);
    for (int i = 0; i < 100 && stb_w.size() < n; i++) tick;
    chk("strobe_timeout", 64'(stb_w.size() >= n), 64'd1);
  endtask

  task automatic check_words(string tag);
    chk({tag, "_count"}, 64'(stb_w.size()), 64'(exp_w.size()));
    foreach (exp_w[i])
      if (i < stb_w.size()) chk($sformatf("%s_word%0d", tag, i), stb_w[i], exp_w[i]);
  endtask

  task automatic clr;
    stb_w.delete(); stb_c.delete(); exp_w.delete();
  endtask

  initial begin
    #3 rst = 1'b0;
    repeat (3) tick;
    chk("reset_outputs", 64'({cmd_ready, busy, instr_strobe, wdata_ready, rsp_valid}), 64'd0);
    chk("reset_instr", accelerator_input, 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    rst = 1'b1;
    tick;
    chk("release_ready", 64'({cmd_ready, busy}), 64'b10);

    // NOP and illegal opcodes are swallowed
    send(4'd0, 14'(32'($urandom)), LW'(3));
    chk("nop_busy", 64'(busy), 64'd0);
    send(4'd7, 14'(32'($urandom)), LW'(2));
    send(4'd15, 14'h1234, LW'(1));
    tick;
    chk("drop_ready", 64'({cmd_ready, busy}), 64'b10);
    chk("drop_no_strobe", 64'(stb_w.size()), 64'd0);

    // LOAD_INP burst crossing the address wrap
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    wq.push_back(d0); wq.push_back(d1); wq.push_back(d2);
    tick;
    n0 = wdr_n;
    send(4'd1, 14'h3FFE, LW'(3));
    wait_idle; tick;
    exp_w.push_back(mkw(4'd1, 14'h3FFE, d0));
    exp_w.push_back(mkw(4'd1, 14'h3FFF, d1));
    exp_w.push_back(mkw(4'd1, 14'h0000, d2));
    check_words("load_wrap");
    if (stb_c.size() == 3) begin
      chk("load_gap1", 64'(stb_c[1] - stb_c[0]), 64'd2);
      chk("load_gap2", 64'(stb_c[2] - stb_c[1]), 64'd2);
    end
    chk("load_wdr_count", 64'(wdr_n - n0), 64'd3);
    clr;

    // LOAD_WT with backpressure before beat 2
    a = int'($urandom_range(0, 16383));
    d0 = $urandom; d1 = $urandom;
    wq.push_back(d0); wq.push_back(d1);
    tick;
    send(4'd2, 14'(a), LW'(2));
    wait_stb(1);
    bf_dir = 1'b1;
    repeat (5) tick;
    chk("bp_no_strobe", 64'(stb_w.size()), 64'd1);
    bf_dir = 1'b0;
    rel = cyc;
    wait_idle; tick;
    exp_w.push_back(mkw(4'd2, 14'(a), d0));
    exp_w.push_back(mkw(4'd2, 14'((a + 1) % 16384), d1));
    check_words("load_bp");
    if (stb_c.size() == 2) chk("bp_release_cycle", 64'(stb_c[1]), 64'(rel));
    clr;

    // READ_OUT with delayed response acceptance
    rd_val = 32'hDEADBEEF;
    rsp_ready = 1'b0;
    send(4'd5, 14'd5, LW'(0));
    for (int i = 0; i < 60 && !rsp_valid; i++) tick;
    rv_c = cyc;
    chk("read_valid", 64'(rsp_valid), 64'd1);
    chk("read_data", 64'(rsp_data), 64'hDEADBEEF);
    if (stb_c.size() == 1) chk("read_latency", 64'(rv_c - stb_c[0]), 64'(RD_LAT + 1));
    exp_w.push_back(mkw(4'd5, 14'd5, 32'd0));
    check_words("read");
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("read_hold", 64'({rsp_valid, cmd_ready, busy}), 64'b101);
      chk("read_hold_data", 64'(rsp_data), 64'hDEADBEEF);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("read_done", 64'({rsp_valid, cmd_ready, busy}), 64'b010);
    clr;

    // len=0 behaves as a single beat
    a = int'($urandom_range(0, 16383));
    d0 = $urandom;
    wq.push_back(d0); wq.push_back(32'hBAD0BAD0);
    tick;
    send(4'd2, 14'(a), LW'(0));
    wait_idle; tick;
    exp_w.push_back(mkw(4'd2, 14'(a), d0));
    check_words("len0");
    chk("len0_left", 64'(wq.size()), 64'd1);
    wq.delete();
    tick;
    clr;

    // Random commands with data stalls and buffer_full noise
    rnd_stall = 1;
    for (int k = 0; k < 12; k++) begin
      opi = int'($urandom_range(0, 4));
      op  = (opi < 2) ? 4'(opi + 1) : (opi == 2 ? 4'd3 : (opi == 3 ? 4'd4 : 4'd6));
      a   = int'($urandom_range(0, 16383));
      len = int'($urandom_range(0, 4));
      if (op == 4'd1 || op == 4'd2) begin
        for (int b = 0; b < ((len == 0) ? 1 : len); b++) begin
          d0 = $urandom;
          wq.push_back(d0);
          exp_w.push_back(mkw(op, 14'((a + b) % 16384), d0));
        end
      end else exp_w.push_back(mkw(op, 14'(a), 32'd0));
      tick;
      send(op, 14'(a), LW'(len));
      wait_idle; tick;
      check_words($sformatf("rnd%0d", k));
      clr;
    end
    rnd_stall = 0;
    tick;

    // Reset in the middle of a burst
    a = int'($urandom_range(0, 16383));
    for (int b = 0; b < 4; b++) wq.push_back($urandom);
    tick;
    send(4'd1, 14'(a), LW'(4));
    wait_stb(2);
    rst = 1'b0;
    #1;
    chk("rst_burst_outputs", 64'({cmd_ready, busy, instr_strobe, wdata_ready, rsp_valid}), 64'd0);
    chk("rst_burst_instr", accelerator_input, 64'd0);
    n0 = stb_w.size();
    repeat (4) tick;
    chk("rst_burst_quiet", 64'(stb_w.size()), 64'(n0));
    wq.delete();
    rst = 1'b1;
    repeat (2) tick;
    clr;
    a = int'($urandom_range(0, 16383));
    d0 = $urandom;
    wq.push_back(d0);
    tick;
    send(4'd1, 14'(a), LW'(1));
    wait_idle; tick;
    exp_w.push_back(mkw(4'd1, 14'(a), d0));
    check_words("after_rst");
    clr;

    // Reset during WAIT_RD: the response must never appear
    rv_seen = 0;
    rd_val = $urandom;
    send(4'd5, 14'd3, LW'(0));
    wait_stb(1);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_rd_outputs", 64'({cmd_ready, busy, rsp_valid}), 64'd0);
    chk("rst_rd_data", 64'(rsp_data), 64'd0);
    repeat (3) tick;
    rst = 1'b1;
    repeat (12) tick;
    chk("rst_rd_no_rsp", 64'(rv_seen), 64'd0);
    chk("rst_rd_idle", 64'({cmd_ready, busy}), 64'b10);

    chk("wdata_ready_alignment", 64'(wdr_bad), 64'd0);
    chk("instr_hold_stable", 64'(hold_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
